// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks long-latency register writes in flight and raises a decode
//            stall on RAW/WAW hazards or when the in-flight table is full.
//            Optional macro SCOREBOARD_WB_BYPASS_EN lets a register being
//            written back this cycle count as already available.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regWrite,
    input  logic        issue_long,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] pending,
    output logic [5:0]  outstanding
);

    localparam logic [5:0] C_MAX = 6'(MAX_OUTSTANDING);

    logic [31:0] pending_q, pending_d;
    logic [5:0]  outstanding_q, outstanding_d;

    logic        w_clr_ev;
    logic [31:0] w_clr_mask;
    logic [31:0] w_eff_pending;
    logic        w_slot_freed;
    logic        w_haz_rs1, w_haz_rs2, w_haz_rd;
    logic        w_long_wr;
    logic        w_full;
    logic        w_set_ev;
    logic [31:0] w_set_mask;

    // Writebacks to x0 or to a register not in flight never count as a clear.
    assign w_clr_ev   = wb_valid && (wb_rd != 5'd0) && pending_q[wb_rd];
    assign w_clr_mask = w_clr_ev ? (32'd1 << wb_rd) : 32'd0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_eff_pending = pending_q & ~w_clr_mask;
`else
    assign w_eff_pending = pending_q;
`endif

    // A retiring entry always frees its table slot for an issue the same cycle.
    assign w_slot_freed = w_clr_ev;

    assign w_haz_rs1 = (issue_rs1 != 5'd0) && w_eff_pending[issue_rs1];
    assign w_haz_rs2 = (issue_rs2 != 5'd0) && w_eff_pending[issue_rs2];
    assign w_haz_rd  = (issue_rd  != 5'd0) && w_eff_pending[issue_rd];

    assign w_long_wr = issue_regWrite && issue_long && (issue_rd != 5'd0);
    assign w_full    = (outstanding_q >= C_MAX) && !w_slot_freed;

    assign stall = issue_valid && !flush &&
                   (w_haz_rs1 || w_haz_rs2 ||
                    (issue_regWrite && w_haz_rd) ||
                    (w_long_wr && w_full));

    assign w_set_ev   = issue_valid && !stall && !flush && w_long_wr;
    assign w_set_mask = w_set_ev ? (32'd1 << issue_rd) : 32'd0;

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        if (flush) begin
            pending_d     = 32'd0;
            outstanding_d = 6'd0;
        end else begin
            // Clear before set so a bypassed same-register reissue stays pending.
            pending_d    = (pending_q & ~w_clr_mask) | w_set_mask;
            pending_d[0] = 1'b0;
            if (w_set_ev && !w_clr_ev && (outstanding_q < C_MAX)) begin
                outstanding_d = outstanding_q + 6'd1;
            end else if (w_clr_ev && !w_set_ev && (outstanding_q != 6'd0)) begin
                outstanding_d = outstanding_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= 32'd0;
            outstanding_q <= 6'd0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed table-driven bench for hazard_scoreboard (MAX_OUTSTANDING=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_regWrite;
    logic        issue_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] pending;
    logic [5:0]  outstanding;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rd       (issue_rd),
        .issue_regWrite (issue_regWrite),
        .issue_long     (issue_long),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .stall          (stall),
        .pending        (pending),
        .outstanding    (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        lng;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_pend;
        logic [5:0]  exp_out;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid    = v.iv;
        issue_rs1      = v.rs1;
        issue_rs2      = v.rs2;
        issue_rd       = v.rd;
        issue_regWrite = v.rw;
        issue_long     = v.lng;
        wb_valid       = v.wbv;
        wb_rd          = v.wbrd;
        flush          = v.fl;
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic lng,
                                input logic wbv, input logic [4:0] wbrd, input logic fl,
                                input logic es, input logic [31:0] ep, input logic [5:0] eo);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.lng = lng;
        v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
        v.exp_stall = es; v.exp_pend = ep; v.exp_out = eo;
        return v;
    endfunction

    initial begin
        //            iv rs1 rs2 rd  rw lng wbv wbrd fl  stall  pend         out
        vecs[0]  = mk(0, 0,  0,  0,  0, 0,  0,  0,   0,  0,     32'h0,       6'd0);
        // load x5 then a dependent add
        vecs[1]  = mk(1, 0,  0,  5,  1, 1,  0,  0,   0,  0,     32'h20,      6'd1);
        vecs[2]  = mk(1, 5,  0,  12, 1, 0,  0,  0,   0,  1,     32'h20,      6'd1);
        vecs[3]  = mk(1, 5,  0,  12, 1, 0,  0,  0,   0,  1,     32'h20,      6'd1);
        vecs[4]  = mk(1, 5,  0,  12, 1, 0,  1,  5,   0,  !C_BYP, 32'h0,      6'd0);
        vecs[5]  = mk(1, 5,  0,  12, 1, 0,  0,  0,   0,  0,     32'h0,       6'd0);
        // fill the table with x1..x4
        vecs[6]  = mk(1, 0,  0,  1,  1, 1,  0,  0,   0,  0,     32'h2,       6'd1);
        vecs[7]  = mk(1, 0,  0,  2,  1, 1,  0,  0,   0,  0,     32'h6,       6'd2);
        vecs[8]  = mk(1, 0,  0,  3,  1, 1,  0,  0,   0,  0,     32'hE,       6'd3);
        vecs[9]  = mk(1, 0,  0,  4,  1, 1,  0,  0,   0,  0,     32'h1E,      6'd4);
        vecs[10] = mk(1, 0,  0,  6,  1, 1,  0,  0,   0,  1,     32'h1E,      6'd4);
        vecs[11] = mk(1, 0,  0,  6,  1, 1,  1,  2,   0,  0,     32'h5A,      6'd4);
        // same-cycle set x7 and clear x3
        vecs[12] = mk(1, 0,  0,  7,  1, 1,  1,  3,   0,  0,     32'hD2,      6'd4);
        // long write to x0 and writeback to non-pending x9
        vecs[13] = mk(1, 0,  0,  0,  1, 1,  1,  9,   0,  0,     32'hD2,      6'd4);
        vecs[14] = mk(0, 0,  0,  0,  0, 0,  1,  0,   0,  0,     32'hD2,      6'd4);
        vecs[15] = mk(0, 0,  0,  0,  0, 0,  1,  1,   0,  0,     32'hD0,      6'd3);
        vecs[16] = mk(1, 0,  0,  8,  1, 1,  0,  0,   0,  0,     32'h1D0,     6'd4);
        // WAW on x8, then flush
        vecs[17] = mk(1, 0,  0,  8,  1, 1,  0,  0,   0,  1,     32'h1D0,     6'd4);
        vecs[18] = mk(1, 0,  0,  8,  1, 1,  0,  0,   1,  0,     32'h0,       6'd0);
        vecs[19] = mk(1, 0,  0,  8,  1, 1,  0,  0,   0,  0,     32'h100,     6'd1);
        vecs[20] = mk(1, 0,  0,  8,  1, 1,  0,  0,   0,  1,     32'h100,     6'd1);
        vecs[21] = mk(1, 0,  8,  9,  1, 0,  0,  0,   0,  1,     32'h100,     6'd1);
        vecs[22] = mk(1, 0,  0,  8,  0, 1,  0,  0,   0,  0,     32'h100,     6'd1);
        vecs[23] = mk(0, 0,  0,  0,  0, 0,  0,  0,   1,  0,     32'h0,       6'd0);

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'd0));
        #2;
        check("reset pending", pending, 32'h0);
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            check($sformatf("row%0d pending", i), pending, vecs[i].exp_pend);
            check($sformatf("row%0d outstanding", i), 32'(outstanding), 32'(vecs[i].exp_out));
        end

        // asynchronous reset while x10 and x11 are in flight
        drive(mk(1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 32'h0, 6'd0));
        @(posedge clk);
        #1;
        drive(mk(1, 0, 0, 11, 1, 1, 0, 0, 0, 0, 32'h0, 6'd0));
        @(posedge clk);
        #1;
        drive(mk(1, 10, 11, 12, 1, 0, 0, 0, 0, 0, 32'h0, 6'd0));
        check("pre-reset pending", pending, 32'hC00);
        check("pre-reset outstanding", 32'(outstanding), 32'd2);
        check("pre-reset stall", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async reset pending", pending, 32'h0);
        check("async reset outstanding", 32'(outstanding), 32'd0);
        check("async reset stall", 32'(stall), 32'd0);
        #1 rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 32'h0, 6'd0));
        @(posedge clk);
        #1;
        check("stale wb pending", pending, 32'h0);
        check("stale wb outstanding", 32'(outstanding), 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'd0));
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
